// File: rtl/stage3_round_pkg.sv
// Shared constants, FSM encoding and key-derived helpers for the round stages.
package stage3_round_pkg;
    localparam int WIDTH = 17;
    localparam int KEYW  = 5;
    localparam int CNTW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Round count 1..8: one extra bit so N=8 is representable.
    function automatic logic [CNTW:0] key_rounds(input logic [KEYW-1:0] key);
        return {1'b0, key[4:2]} + {{CNTW{1'b0}}, 1'b1};
    endfunction

    function automatic logic [2:0] key_rot(input logic [KEYW-1:0] key);
        return {1'b0, key[1:0]} + 3'd1;
    endfunction

    function automatic logic [WIDTH-1:0] key_rcb(input logic [KEYW-1:0] key);
        return {key, key, key, key[1:0]};
    endfunction
endpackage

// File: rtl/stage3_round_fn.sv
// One round: circular left rotate by r, then XOR with the round constant.
module stage3_round_fn
    import stage3_round_pkg::*;
(
    input  logic [WIDTH-1:0] work,
    input  logic [2:0]       r,
    input  logic [WIDTH-1:0] rc_k,
    output logic [WIDTH-1:0] work_next
);
    logic [2*WIDTH-1:0] dbl;

    // Shifting a doubled copy puts the rotated word in the upper half.
    assign dbl       = {work, work} << r;
    assign work_next = dbl[2*WIDTH-1 -: WIDTH] ^ rc_k;
endmodule

// File: rtl/stage3_round.sv
// Third pipeline stage: captures the stage-2 word once, runs 1..8 keyed
// rotate/XOR rounds and presents a sticky result until reset.
module stage3_round
    import stage3_round_pkg::*;
(
    input  logic             clk2,
    input  logic             rst,
    input  logic [KEYW-1:0]  key_bits,
    input  logic [WIDTH-1:0] stg2_out,
    input  logic             stg2_done,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] stg3_out
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [KEYW-1:0]  key_q, key_d;
    logic [CNTW-1:0]  idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] rc_k, work_next;
    logic             last_round;

    assign rc_k       = key_rcb(key_q) ^ {{(WIDTH-CNTW){1'b0}}, idx_q};
    assign last_round = ({1'b0, idx_q} + {{CNTW{1'b0}}, 1'b1}) == key_rounds(key_q);

    stage3_round_fn u_fn (
        .work      (work_q),
        .r         (key_rot(key_q)),
        .rc_k      (rc_k),
        .work_next (work_next)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        key_d   = key_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (stg2_done && !done_q) begin
                    work_d  = stg2_out;
                    key_d   = key_bits;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                work_d = work_next;
                if (last_round) begin
                    out_d   = work_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            out_q   <= '0;
            key_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign stg3_out = out_q;
endmodule

// File: tb/tb_stage3_round.sv
// Randomized bench for stage3_round against an arithmetic reference model.
module tb_stage3_round;
    logic        clk2 = 1'b0;
    logic        rst;
    logic [4:0]  key_bits;
    logic [16:0] stg2_out;
    logic        stg2_done;
    logic        busy, done;
    logic [16:0] stg3_out;

    int total = 0;
    int bad   = 0;

    stage3_round dut (
        .clk2      (clk2),
        .rst       (rst),
        .key_bits  (key_bits),
        .stg2_out  (stg2_out),
        .stg2_done (stg2_done),
        .busy      (busy),
        .done      (done),
        .stg3_out  (stg3_out)
    );

    always #5 clk2 = ~clk2;

    function automatic int n_of(input int key);
        return ((key >> 2) & 7) + 1;
    endfunction

    function automatic int model(input int key, input int data);
        int r, rcb, w;
        r   = (key & 3) + 1;
        rcb = (key << 12) | (key << 7) | (key << 2) | (key & 3);
        w   = data & 32'h1FFFF;
        for (int k = 0; k < n_of(key); k++) begin
            w = ((w << r) | (w >> (17 - r))) & 32'h1FFFF;
            w = w ^ rcb ^ k;
        end
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        stg2_done = 1'b0;
        key_bits = '0;
        stg2_out = '0;
        @(posedge clk2);
        #1 rst = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stg3_out !== 17'h0) begin
            bad++;
            $display("FAIL %s: busy=%b done=%b out=%h, required 0/0/00000", name, busy, done, stg3_out);
        end
    endtask

    // Capture at the next edge, then check busy/done/result every edge up to done.
    task automatic run_one(input string name, input logic [4:0] key, input logic [16:0] data,
                           input bit scramble);
        int n, exp;
        n   = n_of(int'(key));
        exp = model(int'(key), int'(data));
        do_reset();
        key_bits  = key;
        stg2_out  = data;
        stg2_done = 1'b1;
        @(posedge clk2); #1;
        if (scramble) begin
            key_bits = 5'($urandom);
            stg2_out = 17'($urandom);
        end
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || stg3_out !== 17'h0) begin
            bad++;
            $display("FAIL %s capture: busy=%b done=%b out=%h, required 1/0/00000", name, busy, done, stg3_out);
        end
        for (int k = 1; k <= n; k++) begin
            @(posedge clk2); #1;
            if (scramble) begin
                key_bits = 5'($urandom);
                stg2_out = 17'($urandom);
            end
            total++;
            if (k < n) begin
                if (busy !== 1'b1 || done !== 1'b0 || stg3_out !== 17'h0) begin
                    bad++;
                    $display("FAIL %s edge %0d: busy=%b done=%b out=%h, required 1/0/00000", name, k, busy, done, stg3_out);
                end
            end else if (busy !== 1'b0 || done !== 1'b1 || stg3_out !== 17'(exp)) begin
                bad++;
                $display("FAIL %s result: busy=%b done=%b out=%h, required 0/1/%h", name, busy, done, stg3_out, 17'(exp));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stg2_done = 1'b0;
        key_bits = '0;
        stg2_out = '0;
        #2;
        chk_idle("reset_state");
        @(posedge clk2); #1 rst = 1'b0;
        chk_idle("after_reset_release");
    endtask

    task automatic test_idle();
        do_reset();
        stg2_out = 17'h1ABCD;
        key_bits = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk2); #1;
            chk_idle("idle_no_done");
        end
    endtask

    task automatic test_directed();
        run_one("basic", 5'b00000, 17'h00001, 1'b0);
        run_one("const_mix", 5'b00001, 17'h00001, 1'b0);
        run_one("wrap", 5'b00000, 17'h10000, 1'b0);
        run_one("two_rounds_late", 5'b00100, 17'h00001, 1'b1);
        run_one("max_rounds", 5'b11111, 17'h1FFFF, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_one("random", 5'($urandom), 17'($urandom), 1'($urandom));
    endtask

    task automatic test_sticky();
        logic [16:0] exp;
        run_one("sticky_run", 5'b01010, 17'h0F0F0, 1'b0);
        exp = 17'(model(5'b01010, 17'h0F0F0));
        stg2_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stg2_out = 17'($urandom);
            key_bits = 5'($urandom);
            @(posedge clk2); #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b1 || stg3_out !== exp) begin
                bad++;
                $display("FAIL sticky cycle %0d: busy=%b done=%b out=%h, required 0/1/%h", i, busy, done, stg3_out, exp);
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        key_bits  = 5'b11100;
        stg2_out  = 17'h12345;
        stg2_done = 1'b1;
        @(posedge clk2);
        repeat (4) @(posedge clk2);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset busy before rst: got %b, required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        chk_idle("midreset_immediate");
        @(posedge clk2); #1;
        chk_idle("midreset_held");
        rst = 1'b0;
        stg2_done = 1'b0;
        run_one("after_midreset", 5'b11100, 17'h12345, 1'b1);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_directed();
        test_random();
        test_sticky();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
